// File: rtl/pipelined_rca.sv
// Pipelined add/subtract: WIDTH bits split into STAGES chunks, one CW-bit ripple per stage.
// Valid/ready on both sides; the whole pipeline freezes under output backpressure.
module pipelined_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int unsigned CW = WIDTH / STAGES;

    logic             w_en;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_bp;
    logic             w_cin0;

    assign w_bp   = SUB ? ~B : B;
    assign w_cin0 = SUB | CIN;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CW;
        localparam int unsigned HI = LO + CW;

        logic [CW-1:0] w_a_chunk;
        logic [CW-1:0] w_b_chunk;
        logic          w_cin;
        logic          w_vld_in;
        logic [CW:0]   w_add;
        logic [HI-1:0] w_s_next;
        logic          w_load;
        logic          r_vld;
        logic          r_c;
        logic [HI-1:0] r_s;

        if (k == 0) begin : g_src
            assign w_a_chunk = A[CW-1:0];
            assign w_b_chunk = w_bp[CW-1:0];
            assign w_cin     = w_cin0;
            assign w_vld_in  = IN_VALID;
            assign w_s_next  = w_add[CW-1:0];
        end else begin : g_src
            assign w_a_chunk = g_stage[k-1].g_skew.r_a[HI-1:LO];
            assign w_b_chunk = g_stage[k-1].g_skew.r_b[HI-1:LO];
            assign w_cin     = g_stage[k-1].r_c;
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_s_next  = {w_add[CW-1:0], g_stage[k-1].r_s};
        end

        assign w_add  = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CW{1'b0}}, w_cin};
        // Data registers only load for real transactions, so bubbles leave outputs untouched.
        assign w_load = w_en && w_vld_in;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else begin
                if (w_en) begin
                    r_vld <= w_vld_in;
                end
                if (w_load) begin
                    r_c <= w_add[CW];
                    r_s <= w_s_next;
                end
            end
        end

        // Operand bits not yet consumed ride along with the partial sum.
        if (HI < WIDTH) begin : g_skew
            logic [WIDTH-1:HI] w_a_hi;
            logic [WIDTH-1:HI] w_b_hi;
            logic [WIDTH-1:HI] r_a;
            logic [WIDTH-1:HI] r_b;

            if (k == 0) begin : g_hi
                assign w_a_hi = A[WIDTH-1:HI];
                assign w_b_hi = w_bp[WIDTH-1:HI];
            end else begin : g_hi
                assign w_a_hi = g_stage[k-1].g_skew.r_a[WIDTH-1:HI];
                assign w_b_hi = g_stage[k-1].g_skew.r_b[WIDTH-1:HI];
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_a_hi;
                    r_b <= w_b_hi;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic w_c_msb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign w_c_msb = w_a_chunk[CW-1] ^ w_b_chunk[CW-1] ^ w_add[CW-1];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_c_msb ^ w_add[CW];
                end
            end
        end
    end

    assign w_out_valid = g_stage[STAGES-1].r_vld;
    assign w_en        = !w_out_valid || OUT_READY;
    assign IN_READY    = w_en;
    assign OUT_VALID   = w_out_valid;
    assign SUM         = g_stage[STAGES-1].r_s;
    assign COUT        = g_stage[STAGES-1].r_c;
    assign OVF         = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: arithmetic reference model with a per-cycle compare process,
// plus directed vectors with literal expectations.
module tb_pipelined_rca;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             CIN = 1'b0;
    logic             SUB = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             OUT_READY = 1'b1;
    logic             IN_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;
    logic             OUT_VALID;

    pipelined_rca #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .B        (B),
        .CIN      (CIN),
        .SUB      (SUB),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .SUM      (SUM),
        .COUT     (COUT),
        .OVF      (OVF),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   prog;
    } ent_t;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic cin,
                                   logic sub);
        longint ua, ub, sa, sb, full, sres, smax, smin;
        res_t   r;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -(longint'(1) << (WIDTH - 1));
        if (sub) begin
            full   = ua - ub;
            r.cout = (ua >= ub);
            sres   = sa - sb;
        end else begin
            full   = ua + ub + longint'(cin);
            r.cout = (full >= (longint'(1) << WIDTH));
            sres   = sa + sb + longint'(cin);
        end
        r.sum = full[WIDTH-1:0];
        r.ovf = (sres > smax) || (sres < smin);
        return r;
    endfunction

    // Model state: in-order queue; each entry's progress advances on every enabled edge.
    ent_t q[$];
    res_t last_res = '0;

    always @(negedge CLK) begin : mon
        logic exp_valid;
        logic en;
        res_t got;
        exp_valid = (q.size() > 0) && (q[0].prog >= int'(STAGES) - 1);
        en        = !exp_valid || OUT_READY;
        got       = {SUM, COUT, OVF};
        check("m_out_valid", {31'd0, OUT_VALID}, {31'd0, exp_valid});
        check("m_in_ready", {31'd0, IN_READY}, {31'd0, en});
        if (exp_valid) begin
            check("m_result", 32'(got), 32'(q[0].r));
            last_res = q[0].r;
        end else begin
            check("m_hold", 32'(got), 32'(last_res));
        end
        if (RST) begin
            q.delete();
            last_res = '0;
        end else if (en) begin
            if (exp_valid) void'(q.pop_front());
            foreach (q[i]) q[i].prog++;
            if (IN_VALID) q.push_back('{r: model(A, B, CIN, SUB), prog: 0});
        end
    end

    // Call right after a posedge (+#1) with an empty pipeline and OUT_READY=1.
    task automatic run_one(string name, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic cin,
                           logic sub, logic [WIDTH-1:0] es, logic ec, logic eo);
        A = a; B = b; CIN = cin; SUB = sub; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check({name, "_early"}, {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check({name, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
        check({name, "_sum"}, {16'd0, SUM}, {16'd0, es});
        check({name, "_cout"}, {31'd0, COUT}, {31'd0, ec});
        check({name, "_ovf"}, {31'd0, OVF}, {31'd0, eo});
        @(posedge CLK); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    initial begin : main
        logic [WIDTH-1:0] sa[4];
        logic [WIDTH-1:0] sb[4];
        logic             sc[4];
        logic [WIDTH-1:0] es[4];
        logic             ec[4];
        res_t             r;

        // Pin the model to hand-computed values.
        r = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("model_carry", 32'(r), 32'({16'h0000, 1'b1, 1'b0}));
        r = model(16'h8000, 16'h0001, 1'b0, 1'b1);
        check("model_sub_ovf", 32'(r), 32'({16'h7FFF, 1'b1, 1'b1}));
        r = model(16'h0005, 16'h0007, 1'b1, 1'b1);
        check("model_sub_borrow", 32'(r), 32'({16'hFFFE, 1'b0, 1'b0}));

        // Reset held 2 cycles with valid random inputs.
        IN_VALID = 1'b1;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        @(posedge CLK); #1;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        @(negedge CLK);
        check("rst_during_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_during_sum", {16'd0, SUM}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        IN_VALID = 1'b0;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_after_valid", {31'd0, OUT_VALID}, 32'd0);
            check("rst_after_out", {14'd0, SUM, COUT, OVF}, 32'd0);
        end
        @(posedge CLK); #1;

        run_one("carry_full", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("carry_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Back-to-back stream.
        sa = '{16'h0000, 16'hFFFF, 16'h9000, 16'h0020};
        sb = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0A00};
        sc = '{1'b0, 1'b1, 1'b0, 1'b1};
        es = '{16'h0000, 16'hFFFF, 16'h9000, 16'h0A21};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            A = sa[i]; B = sb[i]; CIN = sc[i]; SUB = 1'b0; IN_VALID = 1'b1;
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("stream_valid", {31'd0, OUT_VALID}, 32'd1);
            check("stream_sum", {16'd0, SUM}, {16'd0, es[i]});
            check("stream_cout", {31'd0, COUT}, {31'd0, ec[i]});
            check("stream_ovf", {31'd0, OVF}, 32'd0);
        end
        @(posedge CLK); #1;

        run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        SUB = 1'b0;

        // Backpressure: 6 random ops, 3-cycle stall once output goes valid.
        fork
            begin : feed
                logic acc;
                for (int i = 0; i < 6; i++) begin
                    A = WIDTH'($urandom);
                    B = WIDTH'($urandom);
                    CIN = 1'($urandom);
                    SUB = 1'($urandom);
                    IN_VALID = 1'b1;
                    acc = 1'b0;
                    for (int t = 0; t < 20 && !acc; t++) begin
                        @(negedge CLK);
                        acc = IN_READY;
                        @(posedge CLK); #1;
                    end
                    check("bp_accept", {31'd0, acc}, 32'd1);
                end
                IN_VALID = 1'b0;
            end
            begin : stall
                for (int t = 0; t < 50 && !OUT_VALID; t++) begin
                    @(posedge CLK); #1;
                end
                check("bp_valid_rise", {31'd0, OUT_VALID}, 32'd1);
                OUT_READY = 1'b0;
                for (int t = 0; t < 3; t++) begin
                    @(negedge CLK);
                    check("bp_in_ready_low", {31'd0, IN_READY}, 32'd0);
                    @(posedge CLK); #1;
                end
                OUT_READY = 1'b1;
            end
        join
        repeat (12) @(posedge CLK);
        #1;
        check("bp_drained", {31'd0, OUT_VALID}, 32'd0);

        // Reset mid-flight discards three accepted ops.
        for (int i = 0; i < 3; i++) begin
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
            CIN = 1'($urandom);
            SUB = 1'b0;
            IN_VALID = 1'b1;
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        IN_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("mf_no_valid", {31'd0, OUT_VALID}, 32'd0);
        end
        @(posedge CLK); #1;
        run_one("mf_post", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
# pipelined_rca

Parametrised, pipelined successor to the team's 4-bit combinational ripple-carry adder. It adds or subtracts two WIDTH-bit operands, with carry-in, across STAGES register stages, each stage rippling one WIDTH/STAGES-bit chunk. A valid/ready handshake on both sides sustains one operation per cycle with backpressure. It sits in datapaths where the combinational adder no longer meets timing at larger widths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  reset: synchronous, active-high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in; used only when SUB=0.
- SUB  input  1  0: A+B+CIN; 1: A−B (computed as A+~B+1; CIN ignored).
- IN_VALID  input  1  A/B/CIN/SUB valid this cycle.
- IN_READY  output  1  block accepts input this cycle.
- SUM  output  WIDTH  result.
- COUT  output  1  carry out of MSB (SUB=1: 1 = no borrow).
- OVF  output  1  two's-complement signed overflow.
- OUT_VALID  output  1  SUM/COUT/OVF valid.
- OUT_READY  input  1  downstream consumes result this cycle.

## Operation
- Stage k (k=0..STAGES-1) adds chunk k of A and B' (B' = SUB ? ~B : B), bits [k*CW +: CW], plus the carry registered from stage k−1. Stage 0 carry-in = SUB ? 1 : CIN.
- Lower chunks of SUM and upper chunks of A/B' travel in skew registers alongside the carry. No stage carries more than one CW-bit ripple between registers.
- Each stage holds a valid bit; a transaction moves one stage per enabled edge.
- Global enable EN = !OUT_VALID || OUT_READY. All stage registers, including their valid bits, advance only when EN=1. When EN=0 the whole pipeline freezes, and bubbles are not collapsed.
- IN_READY = EN (combinational). An input is accepted on an edge where IN_VALID && IN_READY. If IN_VALID=0 with EN=1, a bubble (valid=0) enters stage 0.
- A result is consumed on an edge where OUT_VALID && OUT_READY.
- COUT = carry out of bit WIDTH−1. OVF = carry into MSB XOR carry out of MSB.
- Results emerge strictly in acceptance order. No drop, no duplication.
- Output registers hold their value while OUT_VALID && !OUT_READY. SUM/COUT/OVF are don't-care-stable (they retain their last value) when OUT_VALID=0.

## Timing
- Reset: every stage valid bit = 0, OUT_VALID=0, SUM=0, COUT=0, OVF=0, all internal carry/skew registers = 0. IN_READY=1 in the first cycle after reset.
- RST asserted mid-operation discards all in-flight transactions at that edge. RST overrides EN and IN_VALID.
- Latency: a transaction accepted at edge n with no stall raises OUT_VALID after edge n+STAGES−1, i.e. STAGES cycles accept-to-output. STAGES=1 degenerates to one registered adder with latency 1.
- Throughput: 1 transaction/cycle while OUT_READY=1.
- Each stall cycle (OUT_VALID=1, OUT_READY=0) adds exactly one cycle to every in-flight transaction's latency.
- Same-cycle consume-and-accept is legal: with OUT_VALID=1 and OUT_READY=1, the result is consumed and a new input is accepted on the same edge.
- Inputs are sampled only on accepting edges. A/B/CIN/SUB may change freely otherwise.

## Test plan
Defaults WIDTH=16, STAGES=4.
- Reset: RST=1 for 2 cycles with IN_VALID=1 and random operands → OUT_VALID=0, SUM=0x0000, COUT=0, OVF=0 during reset and for 4 cycles after; IN_READY=1 after release.
- Full-width carry: A=0xFFFF, B=0x0001, CIN=0, SUB=0 → exactly 4 cycles later SUM=0x0000, COUT=1, OVF=0. Also A=0x7FFF, B=0x0001 → SUM=0x8000, COUT=0, OVF=1.
- Streaming: back-to-back inputs (0x0000+0x0000+0), (0xFFFF+0xFFFF+1), (0x9000+0x0000+0), (0x0020+0x0A00+1) with OUT_READY=1 → on consecutive cycles SUM=0x0000/C0, 0xFFFF/C1, 0x9000/C0, 0x0A21/C0.
- Subtract: SUB=1, A=0x0005, B=0x0007, CIN=1 → SUM=0xFFFE, COUT=0, OVF=0. SUB=1, A=0x8000, B=0x0001 → SUM=0x7FFF, COUT=1, OVF=1.
- Backpressure: stream 6 random operations and hold OUT_READY=0 for 3 cycles once OUT_VALID rises → IN_READY=0 and SUM/COUT/OVF stable during the stall; all 6 results match the reference model in order.
- Reset mid-flight: accept 3 operations, assert RST for 1 cycle → OUT_VALID stays 0 until a new post-reset operation completes 4 cycles after acceptance; none of the 3 discarded results ever appear.
